// File: rtl/acc_requantizer.sv
// acc_requantizer: converts 2*DATA_WIDTH signed accumulator results into
// DATA_WIDTH activations (round-half-up, arithmetic shift, saturate, optional
// ReLU). Results are buffered in a small credit-managed output FIFO.
// A saturation event counter is kept for debug.
// Optional feature macro: REQUANT_RELU_EN (adds runtime ReLU selected by relu_en).
module acc_requantizer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_stats,
  input  logic                      relu_en,
  input  logic                      acc_valid,
  output logic                      acc_ready,
  input  logic [2*DATA_WIDTH-1:0]   acc_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      sat_flag,
  output logic [15:0]               sat_count
);

  localparam int IW = 2 * DATA_WIDTH;         // accumulator width
  localparam int SW = IW + 1 - FRAC_BITS;     // width of the shifted value
  localparam int AW = $clog2(FIFO_DEPTH);     // FIFO pointer width
  localparam int CW = AW + 1;                 // FIFO occupancy width

  localparam logic [IW:0]          RND     = (IW + 1)'(1) << (FRAC_BITS - 1);
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
  localparam logic [CW:0]          DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  // Pipeline state
  logic                         s1_valid_reg;
  logic signed [SW-1:0]         s1_data_reg;
  logic                         s2_valid_reg;
  logic [DATA_WIDTH-1:0]        s2_data_reg;
  logic                         s2_sat_reg;
  logic [DATA_WIDTH-1:0]        s2_data_next;
  logic                         s2_sat_next;

  // FIFO state
  logic [DATA_WIDTH:0]          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr_reg;
  logic [AW-1:0]                rd_ptr_reg;
  logic [CW-1:0]                count_reg;
  logic [DATA_WIDTH:0]          head;
  logic                         push;
  logic                         pop;

  logic [15:0]                  sat_count_reg;
  logic signed [IW:0]           t_sum;
  logic [CW:0]                  credits_used;
  logic                         unused_frac;

  // Round by adding half an output LSB before the arithmetic shift; the
  // extra sign bit keeps the addition from overflowing.
  assign t_sum       = $signed({acc_in[IW-1], acc_in}) + $signed(RND);
  assign unused_frac = ^t_sum[FRAC_BITS-1:0];

  // Every beat in flight already owns a FIFO slot, so the stages never stall.
  assign credits_used = {1'b0, count_reg}
                      + {{CW{1'b0}}, s1_valid_reg}
                      + {{CW{1'b0}}, s2_valid_reg};
  assign acc_ready    = credits_used < DEPTH_C;

  assign push = s2_valid_reg;
  assign pop  = out_valid && out_ready;

  // Stage 1: capture the rounded, shifted accumulator value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      s1_valid_reg <= acc_valid && acc_ready;
      s1_data_reg  <= t_sum[IW:FRAC_BITS];
    end
  end

  // Stage 2 combinational: clamp to the output range, then optional ReLU.
  always_comb begin
    s2_sat_next  = 1'b0;
    s2_data_next = s1_data_reg[DATA_WIDTH-1:0];
    if (s1_data_reg > SAT_MAX) begin
      s2_sat_next  = 1'b1;
      s2_data_next = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (s1_data_reg < SAT_MIN) begin
      s2_sat_next  = 1'b1;
      s2_data_next = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end
`ifdef REQUANT_RELU_EN
    if (relu_en && s2_data_next[DATA_WIDTH-1]) begin
      s2_data_next = '0;
    end
`endif
  end

`ifndef REQUANT_RELU_EN
  logic unused_relu;
  assign unused_relu = relu_en;
`endif

  // Stage 2 register: saturated/ReLU'd value heading into the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
      s2_sat_reg   <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_data_reg  <= s2_data_next;
      s2_sat_reg   <= s2_sat_next;
    end
  end

  // FIFO storage: contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {s2_sat_reg, s2_data_reg};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Saturation counter: clear wins over increment, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count_reg <= '0;
    end else if (clear_stats) begin
      sat_count_reg <= '0;
    end else if (push && s2_sat_reg && (sat_count_reg != 16'hFFFF)) begin
      sat_count_reg <= sat_count_reg + 16'd1;
    end
  end

  assign head      = fifo_mem[rd_ptr_reg];
  assign out_valid = (count_reg != '0);
  assign out_data  = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign sat_flag  = out_valid ? head[DATA_WIDTH] : 1'b0;
  assign sat_count = sat_count_reg;

endmodule

// File: tb/tb_acc_requantizer.sv
// Scoreboard bench for acc_requantizer (DATA_WIDTH=16, FRAC_BITS=8, FIFO_DEPTH=4).
// Stimulus pushes hand-computed {sat, data} into a queue; an independent
// monitor pops and compares on every output transfer.
module tb_acc_requantizer;

  logic        clk;
  logic        rst_n;
  logic        clear_stats;
  logic        relu_en;
  logic        acc_valid;
  logic        acc_ready;
  logic [31:0] acc_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        sat_flag;
  logic [15:0] sat_count;

  int tests = 0;
  int fails = 0;
  logic [16:0] exp_q[$];

  acc_requantizer #(.DATA_WIDTH(16), .FRAC_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear_stats(clear_stats), .relu_en(relu_en),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_in(acc_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_flag(sat_flag), .sat_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [31:0] v, input logic [16:0] exp);
    int guard = 0;
    acc_in    = v;
    acc_valid = 1'b1;
    while (!acc_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      tests++;
      fails++;
      $display("[TB] FAIL send_timeout: acc_ready stuck at %0b, expected 1", acc_ready);
    end else begin
      exp_q.push_back(exp);
      @(negedge clk);
    end
    acc_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check(name, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: sample mid-low-phase, a transfer happens on the next rising edge.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_pop: got 0x%0h, expected no output", {sat_flag, out_data});
        end else begin
          e = exp_q.pop_front();
          $display("[TB] pop data=0x%04h sat=%0b (want 0x%04h sat=%0b)", out_data, sat_flag, e[15:0], e[16]);
          check("pop", {15'd0, sat_flag, out_data}, {15'd0, e});
        end
      end
    end
  end

  logic [31:0] t5_in  [8] = '{32'h00000100, 32'h00000280, 32'hFFFFFE00, 32'h00007FFF,
                              32'h007FFF00, 32'h007FFF80, 32'hFF800000, 32'hFF7FFF7F};
  logic [16:0] t5_exp [8] = '{17'h00001, 17'h00003, 17'h0FFFE, 17'h00080,
                              17'h07FFF, 17'h17FFF, 17'h08000, 17'h18000};

  initial begin
    rst_n = 1'b0; clear_stats = 1'b0; relu_en = 1'b0;
    acc_valid = 1'b0; acc_in = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_sat_flag", sat_flag, 0);
    check("reset_acc_ready", acc_ready, 1);
    check("reset_sat_count", sat_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic conversion with latency check
    send(32'h00012380, 17'h00124);
    check("lat_e0", out_valid, 0);
    @(negedge clk);
    check("lat_e1", out_valid, 0);
    @(negedge clk);
    check("lat_e2", out_valid, 1);
    wait_empty("t1_drain");

    // 2: round-half-up boundary
    send(32'hFFFFFF80, 17'h00000);
    send(32'hFFFFFF7F, 17'h0FFFF);
    wait_empty("t2_drain");
    check("t2_sat_count", sat_count, 0);

    // 3: saturation both ways, then clear
    send(32'h01000000, 17'h17FFF);
    send(32'h80000000, 17'h18000);
    wait_empty("t3_drain");
    check("t3_sat_count", sat_count, 2);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    check("t3_cleared", sat_count, 0);

    // 4: backpressure, credits stop after four accepts
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(32'(k) << 8, 17'(k));
    check("t4_ready_low", acc_ready, 0);
    repeat (3) @(negedge clk);
    check("t4_head", out_data, 16'h0001);
    @(negedge clk);
    check("t4_head_stable", out_data, 16'h0001);
    check("t4_still_blocked", acc_ready, 0);
    fork
      begin
        send(32'h00000500, 17'h00005);
        send(32'h00000600, 17'h00006);
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_empty("t4_drain");

    // 5: continuous input with toggling consumer
    fork
      begin
        repeat (40) @(negedge clk) out_ready = ~out_ready;
      end
      begin
        for (int r = 0; r < 2; r++)
          for (int i = 0; i < 8; i++) send(t5_in[i], t5_exp[i]);
      end
    join
    out_ready = 1'b1;
    wait_empty("t5_drain");
    check("t5_sat_count", sat_count, 4);

    // 6: ReLU (or pass-through when the feature is not built)
    relu_en = 1'b1;
`ifdef REQUANT_RELU_EN
    send(32'hFFFF0000, 17'h00000);
`else
    send(32'hFFFF0000, 17'h0FF00);
`endif
    send(32'h00000200, 17'h00002);
    wait_empty("t6_drain");
    relu_en = 1'b0;

    // 7: reset with buffered beats
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    out_ready = 1'b0;
    send(32'h00000100, 17'h00001);
    send(32'h01000000, 17'h17FFF);
    send(32'h00000200, 17'h00002);
    repeat (4) @(negedge clk);
    check("t7_buffered", out_valid, 1);
    check("t7_sat_before", sat_count, 1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", out_valid, 0);
    check("t7_rst_sat_count", sat_count, 0);
    check("t7_rst_data", out_data, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t7_ready_after", acc_ready, 1);
    @(negedge clk);
    out_ready = 1'b1;
    send(32'h00000300, 17'h00003);
    wait_empty("t7_clean");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
